// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
package lsu_pkg;

    localparam int WORD_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    function automatic int lane_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int LANE_W = lane_bits(WORD_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane extract (loads) and merge (read-modify-write stores), little-endian.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WORD*WIDTH-1:0]      word_i,
    input  logic [lane_bits(WORD)-1:0] lane_i,
    input  logic [WIDTH-1:0]           byte_i,
    output logic [WORD*WIDTH-1:0]      extract_o,
    output logic [WORD*WIDTH-1:0]      merge_o
);

    always_comb begin
        extract_o              = '0;
        extract_o[WIDTH-1:0]   = word_i[lane_i*WIDTH +: WIDTH];
        merge_o                = word_i;
        merge_o[lane_i*WIDTH +: WIDTH] = byte_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a CPU request port to a registered-read RAM.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned word accesses with resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD       = WORD_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_byte,
    input  logic [WORD*WIDTH-1:0] req_addr,
    input  logic [WORD*WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [WORD*WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [WORD*WIDTH-1:0] mem_ad,
    output logic [WORD*WIDTH-1:0] mem_d,
    output logic                  mem_we,
    input  logic [WORD*WIDTH-1:0] mem_q
);

    localparam int DW = WORD * WIDTH;
    localparam int LW = lane_bits(WORD);

    // The RAM word address must fit inside the shifted byte address.
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > DW - LW) begin : g_bad_addr_width
        $error("ADDR_WIDTH out of range");
    end

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic            byte_q, byte_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            req_mis;
    logic            cap_mis;
    logic [LW-1:0]   lane;
    logic [DW-1:0]   lane_rdata;
    logic [DW-1:0]   lane_merged;

    assign lane = addr_q[LW-1:0];

`ifdef LSU_ALIGN_CHECK_EN
    assign req_mis = !req_byte && (req_addr[LW-1:0] != '0);
    assign cap_mis = !byte_q && (lane != '0);
`else
    assign req_mis = 1'b0;
    assign cap_mis = 1'b0;
`endif

    lsu_byte_lane #(
        .WORD  (WORD),
        .WIDTH (WIDTH)
    ) u_lane (
        .word_i    (mem_q),
        .lane_i    (lane),
        .byte_i    (wdata_q[WIDTH-1:0]),
        .extract_o (lane_rdata),
        .merge_o   (lane_merged)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    byte_d  = req_byte;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_mis)
                        state_d = S_RESP;
                    else if (!req_we || req_byte)
                        state_d = S_RD;
                    else
                        state_d = S_WR;
                end
            end
            // Byte stores read first so the merge sees the old word.
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_we     = (state_q == S_WR);
        mem_ad     = addr_q >> LW;
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid && cap_mis;
        mem_d      = '0;
        resp_rdata = '0;
        if (state_q == S_WR)
            mem_d = byte_q ? lane_merged : wdata_q;
        if (resp_valid && !we_q && !cap_mis)
            resp_rdata = byte_q ? lane_rdata : mem_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered-read RAM model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_ad;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_q;

    logic [31:0] ram [256];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int accepts = 0;
    int issued = 0;
    bit cont = 1'b0;

    load_store_unit #(
        .WORD       (4),
        .WIDTH      (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ad     (mem_ad),
        .mem_d      (mem_d),
        .mem_we     (mem_we),
        .mem_q      (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            ram[mem_ad[7:0]] <= mem_d;
        mem_q <= ram[mem_ad[7:0]];
    end

    always @(posedge clk)
        if (rst_n && req_valid && req_ready)
            accepts++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mem_we)
            we_cnt++;
        if (resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %h err %b expected none",
                         resp_rdata, resp_err);
            end else begin
                e = q.pop_front();
                check("resp_rdata", resp_rdata, e.rd);
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                check("latency", cyc - e.acc, e.lat);
            end
        end else begin
            check("rdata_idle", resp_rdata, 32'h0);
        end
    end

    task automatic issue(input bit we, input bit byt,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input bit err, input int lat);
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = byt;
        req_addr  = addr;
        req_wdata = wd;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready;
            @(posedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept addr %h", addr);
            req_valid = 1'b0;
            return;
        end
        #1;
        q.push_back('{rd, err, lat, cyc});
        issued++;
        check("ready_busy", {31'b0, req_ready}, 32'h0);
        req_we    = ~we;
        req_byte  = ~byt;
        req_addr  = ~addr;
        req_wdata = ~wd;
        if (!cont)
            req_valid = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++)
            ram[i] = '0;

        #12;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_ad", mem_ad, 32'h0);
        check("rst_mem_d", mem_d, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {31'b0, req_ready}, 32'h1);

        issue(1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        check("ram_word4", ram[4], 32'hDEADBEEF);
        issue(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

        issue(1, 0, 32'h20, 32'h11223344, 32'h0, 0, 2);
        issue(0, 1, 32'h20, 32'h0, 32'h44, 0, 2);
        issue(0, 1, 32'h21, 32'h0, 32'h33, 0, 2);
        issue(0, 1, 32'h22, 32'h0, 32'h22, 0, 2);
        issue(0, 1, 32'h23, 32'h0, 32'h11, 0, 2);

        w0 = we_cnt;
        issue(1, 1, 32'h22, 32'hFFFFFFAB, 32'h0, 0, 3);
        check("rmw_we_cycles", we_cnt - w0, 32'h1);
        check("ram_word8_rmw", ram[8], 32'h11AB3344);
        issue(0, 0, 32'h20, 32'h0, 32'h11AB3344, 0, 2);

        cont = 1'b1;
        issue(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
        issue(0, 1, 32'h23, 32'h0, 32'h11, 0, 2);
        issue(1, 0, 32'h30, 32'h01020304, 32'h0, 0, 2);
        issue(0, 1, 32'h31, 32'h0, 32'h03, 0, 2);
        issue(0, 0, 32'h30, 32'h0, 32'h01020304, 0, 2);
        cont = 1'b0;
        req_valid = 1'b0;
        check("ram_word12", ram[12], 32'h01020304);

        // Reset during the write phase of a byte store.
        check("ready_pre_rmw", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 32'h21;
        req_wdata = 32'h55;
        @(posedge clk);
        #1;
        issued++;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wr_mem_we", {31'b0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_we", {31'b0, mem_we}, 32'h0);
        check("rst_no_resp", {31'b0, resp_valid}, 32'h0);
        check("rst_ready_mid", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ram_word8_kept", ram[8], 32'h11AB3344);
        issue(0, 0, 32'h20, 32'h0, 32'h11AB3344, 0, 2);

`ifdef LSU_ALIGN_CHECK_EN
        issue(1, 0, 32'h21, 32'hCAFEF00D, 32'h0, 1, 1);
        check("ram_word8_mis", ram[8], 32'h11AB3344);
        issue(0, 0, 32'h22, 32'h0, 32'h0, 1, 1);
`else
        issue(1, 0, 32'h21, 32'hCAFEF00D, 32'h0, 0, 2);
        check("ram_word8_mis", ram[8], 32'hCAFEF00D);
        issue(0, 0, 32'h22, 32'h0, 32'hCAFEF00D, 0, 2);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", q.size(), 32'h0);
        check("accept_count", accepts, issued);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
